// File: rtl/npc_fetch_ctl_if.sv
// rtl/npc_fetch_ctl_if.sv - fetch-PC control bundle between pipeline/CP0 and the fetch unit
interface npc_fetch_ctl_if;
    logic        stall_i;
    logic [1:0]  npc_sel_D_i;
    logic        brh_D_i;
    logic [31:0] pc_D_i;
    logic [25:0] imm26_D_i;
    logic [31:0] rs_D_i;
    logic        exc_req_i;
    logic        eret_i;
    logic [31:0] epc_i;
    logic [31:0] pc_F_o;
    logic        bd_F_o;
    logic        flush_D_o;
    logic        adel_F_o;

    modport master (
        output stall_i, npc_sel_D_i, brh_D_i, pc_D_i, imm26_D_i, rs_D_i,
               exc_req_i, eret_i, epc_i,
        input  pc_F_o, bd_F_o, flush_D_o, adel_F_o
    );

    modport slave (
        input  stall_i, npc_sel_D_i, brh_D_i, pc_D_i, imm26_D_i, rs_D_i,
               exc_req_i, eret_i, epc_i,
        output pc_F_o, bd_F_o, flush_D_o, adel_F_o
    );
endinterface

// File: rtl/npc_fetch_ctl.sv
// rtl/npc_fetch_ctl.sv - registered F-stage PC with branch/jump/exception/eret next-PC selection
module npc_fetch_ctl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IMEM_END   = 32'h0000_6FFC,
    parameter int          DELAY_SLOT = 1
) (
    input  logic            clk,
    input  logic            reset,
    npc_fetch_ctl_if.slave  bus
);
    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_J   = 2'd2;
    localparam logic [1:0] SEL_JR  = 2'd3;
    localparam logic       W_DS    = (DELAY_SLOT != 0);

    logic [31:0] r_pc;
    logic [31:0] w_pc4d;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_tgt;
    logic [31:0] w_nxt;
    logic        w_redir;
    logic        w_adel;

    assign w_pc4d   = bus.pc_D_i + 32'd4;
    assign w_br_tgt = w_pc4d + {{14{bus.imm26_D_i[15]}}, bus.imm26_D_i[15:0], 2'b00};
    assign w_j_tgt  = {w_pc4d[31:28], bus.imm26_D_i, 2'b00};

    always_comb begin
        w_tgt   = w_pc4d;
        w_redir = 1'b0;
        case (bus.npc_sel_D_i)
            SEL_BR: begin
                w_tgt   = w_br_tgt;
                w_redir = bus.brh_D_i;
            end
            SEL_J: begin
                w_tgt   = w_j_tgt;
                w_redir = 1'b1;
            end
            SEL_JR: begin
                w_tgt   = bus.rs_D_i;
                w_redir = 1'b1;
            end
            default: begin
                w_tgt   = w_pc4d;
                w_redir = 1'b0;
            end
        endcase
    end

    // CP0 redirects beat a stall: the faulting/returning flow must not wait on a hazard.
    always_comb begin
        if (bus.exc_req_i)
            w_nxt = EXC_VECTOR;
        else if (bus.eret_i)
            w_nxt = bus.epc_i;
        else if (bus.stall_i)
            w_nxt = r_pc;
        else if (w_redir)
            w_nxt = w_tgt;
        else
            w_nxt = r_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= RESET_PC;
        else
            r_pc <= w_nxt;
    end

    // Bad fetch addresses are only flagged; CP0 raises AdEL when the instruction reaches M.
    assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < RESET_PC) || (r_pc > IMEM_END);

    assign bus.pc_F_o    = r_pc;
    assign bus.adel_F_o  = w_adel;
    assign bus.bd_F_o    = !reset && W_DS && (bus.npc_sel_D_i != SEL_SEQ);
    assign bus.flush_D_o = !reset && (bus.exc_req_i || bus.eret_i ||
                                      (!W_DS && w_redir && !bus.stall_i));
endmodule

// File: tb/tb_npc_fetch_ctl.sv
// tb/tb_npc_fetch_ctl.sv - scoreboard bench driving delay-slot and no-delay-slot instances in lockstep
module tb_npc_fetch_ctl;
    logic clk;
    logic reset;

    npc_fetch_ctl_if bus1 ();
    npc_fetch_ctl_if bus0 ();

    assign bus0.stall_i     = bus1.stall_i;
    assign bus0.npc_sel_D_i = bus1.npc_sel_D_i;
    assign bus0.brh_D_i     = bus1.brh_D_i;
    assign bus0.pc_D_i      = bus1.pc_D_i;
    assign bus0.imm26_D_i   = bus1.imm26_D_i;
    assign bus0.rs_D_i      = bus1.rs_D_i;
    assign bus0.exc_req_i   = bus1.exc_req_i;
    assign bus0.eret_i      = bus1.eret_i;
    assign bus0.epc_i       = bus1.epc_i;

    npc_fetch_ctl #(.DELAY_SLOT(1)) u_ds1 (.clk(clk), .reset(reset), .bus(bus1));
    npc_fetch_ctl #(.DELAY_SLOT(0)) u_ds0 (.clk(clk), .reset(reset), .bus(bus0));

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        bd1;
        logic        fl1;
        logic        fl0;
        logic        adel;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".pc1"},   bus1.pc_F_o,           e.pc);
            chk({e.name, ".pc0"},   bus0.pc_F_o,           e.pc);
            chk({e.name, ".bd1"},   32'(bus1.bd_F_o),      32'(e.bd1));
            chk({e.name, ".bd0"},   32'(bus0.bd_F_o),      32'd0);
            chk({e.name, ".fl1"},   32'(bus1.flush_D_o),   32'(e.fl1));
            chk({e.name, ".fl0"},   32'(bus0.flush_D_o),   32'(e.fl0));
            chk({e.name, ".adel1"}, 32'(bus1.adel_F_o),    32'(e.adel));
            chk({e.name, ".adel0"}, 32'(bus0.adel_F_o),    32'(e.adel));
        end
    end

    // Inputs for one cycle plus the outputs expected during that same cycle.
    task automatic step(input string nm, input logic rst, input logic [1:0] sel,
                        input logic brh, input logic [31:0] pcd, input logic [25:0] imm,
                        input logic [31:0] rs, input logic stall, input logic exc,
                        input logic eret, input logic [31:0] epc,
                        input logic [31:0] e_pc, input logic e_bd1, input logic e_fl1,
                        input logic e_fl0, input logic e_adel);
        exp_t e;
        @(posedge clk);
        #1;
        reset            = rst;
        bus1.npc_sel_D_i = sel;
        bus1.brh_D_i     = brh;
        bus1.pc_D_i      = pcd;
        bus1.imm26_D_i   = imm;
        bus1.rs_D_i      = rs;
        bus1.stall_i     = stall;
        bus1.exc_req_i   = exc;
        bus1.eret_i      = eret;
        bus1.epc_i       = epc;
        e.name = nm; e.pc = e_pc; e.bd1 = e_bd1; e.fl1 = e_fl1; e.fl0 = e_fl0; e.adel = e_adel;
        sb.push_back(e);
    endtask

    task automatic seq(input string nm, input logic [31:0] e_pc, input logic e_adel);
        step(nm, 0, 2'd0, 0, 32'h0, 26'h0, 32'h0, 0, 0, 0, 32'h0, e_pc, 0, 0, 0, e_adel);
    endtask

    initial begin
        reset            = 1'b1;
        bus1.npc_sel_D_i = 2'd0;
        bus1.brh_D_i     = 1'b0;
        bus1.pc_D_i      = 32'h0;
        bus1.imm26_D_i   = 26'h0;
        bus1.rs_D_i      = 32'h0;
        bus1.stall_i     = 1'b0;
        bus1.exc_req_i   = 1'b0;
        bus1.eret_i      = 1'b0;
        bus1.epc_i       = 32'h0;

        step("rst", 1, 2'd0, 0, 32'h0, 26'h0, 32'h0, 0, 0, 0, 32'h0, 32'h3000, 0, 0, 0, 0);
        seq("run0", 32'h3000, 0);
        seq("run1", 32'h3004, 0);
        seq("run2", 32'h3008, 0);
        step("br_back", 0, 2'd1, 1, 32'h3010, 26'h000FFFC, 32'h0, 0, 0, 0, 32'h0,
             32'h300C, 1, 0, 1, 0);
        step("br_ntkn", 0, 2'd1, 0, 32'h3000, 26'h0000010, 32'h0, 0, 0, 0, 32'h0,
             32'h3004, 1, 0, 0, 0);
        step("jump", 0, 2'd2, 0, 32'h3000, 26'h0000C10, 32'h0, 0, 0, 0, 32'h0,
             32'h3008, 1, 0, 1, 0);
        step("jr_mis", 0, 2'd3, 0, 32'h3000, 26'h0, 32'h3022, 0, 0, 0, 32'h0,
             32'h3040, 1, 0, 1, 0);
        seq("at_mis", 32'h3022, 1);
        step("jr_high", 0, 2'd3, 0, 32'h3000, 26'h0, 32'h8000, 0, 0, 0, 32'h0,
             32'h3026, 1, 0, 1, 1);
        seq("at_high", 32'h8000, 1);
        step("stall0", 0, 2'd2, 0, 32'h3000, 26'h0000C20, 32'h0, 1, 0, 0, 32'h0,
             32'h8004, 1, 0, 0, 1);
        step("stall1", 0, 2'd2, 0, 32'h3000, 26'h0000C20, 32'h0, 1, 0, 0, 32'h0,
             32'h8004, 1, 0, 0, 1);
        step("unstall", 0, 2'd2, 0, 32'h3000, 26'h0000C20, 32'h0, 0, 0, 0, 32'h0,
             32'h8004, 1, 0, 1, 1);
        seq("at_jtgt", 32'h3080, 0);
        step("exc_eret", 0, 2'd2, 0, 32'h3000, 26'h0000C10, 32'h0, 1, 1, 1, 32'h3050,
             32'h3084, 1, 1, 1, 0);
        seq("at_vec", 32'h4180, 0);
        step("eret", 0, 2'd0, 0, 32'h0, 26'h0, 32'h0, 0, 0, 1, 32'h3050,
             32'h4184, 0, 1, 1, 0);
        seq("at_epc", 32'h3050, 0);
        step("rst_mid", 1, 2'd3, 0, 32'h3000, 26'h0, 32'h5000, 0, 1, 0, 32'h0,
             32'h3054, 0, 0, 0, 0);
        seq("after_rst", 32'h3000, 0);
        seq("resume", 32'h3004, 0);
        step("jr_end", 0, 2'd3, 0, 32'h3000, 26'h0, 32'h6FFC, 0, 0, 0, 32'h0,
             32'h3008, 1, 0, 1, 0);
        seq("at_end", 32'h6FFC, 0);
        seq("past_end", 32'h7000, 1);
        step("jr_low", 0, 2'd3, 0, 32'h3000, 26'h0, 32'h2FFC, 0, 0, 0, 32'h0,
             32'h7004, 1, 0, 1, 1);
        seq("at_low", 32'h2FFC, 1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
